// File: rtl/lstm_pkg.sv
// lstm_pkg: gate indices, FSM encoding and fixed-point helpers for lstm_seq_cell.
package lstm_pkg;

    localparam int GATE_I = 0;
    localparam int GATE_F = 1;
    localparam int GATE_G = 2;
    localparam int GATE_O = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATE   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_OUT    = 2'd3
    } lstm_state_e;

    function automatic longint sat(input longint v, input int width);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (width - 1)) - 1;
        lo = -(longint'(1) <<< (width - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic sat_hit(input longint v, input int width);
        return sat(v, width) != v;
    endfunction

    // clamp(pre/4 + 0.5, 0, 1.0); the divide is a floor shift
    function automatic longint hard_sigmoid(input longint pre, input int frac);
        longint one;
        longint v;
        one = longint'(1) <<< frac;
        v = (pre >>> 2) + (one >>> 1);
        if (v < 0) return 0;
        if (v > one) return one;
        return v;
    endfunction

    function automatic longint hard_tanh(input longint pre, input int frac);
        longint one;
        one = longint'(1) <<< frac;
        if (pre > one) return one;
        if (pre < -one) return -one;
        return pre;
    endfunction

endpackage

// File: rtl/lstm_mac.sv
// lstm_mac: combinational a*b>>>FRAC + addend, saturated to WIDTH.
// The clamp indicator port exists only with LSTM_SAT_FLAG_EN.
module lstm_mac
    import lstm_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [WIDTH+3:0] addend,
    output logic signed [WIDTH-1:0] y
`ifdef LSTM_SAT_FLAG_EN
    ,
    output logic                    clamped
`endif
);

    localparam int AW = WIDTH + 4;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]      acc;

    assign prod = a * b;
    assign acc  = AW'(prod >>> FRAC) + addend;
    assign y    = WIDTH'(sat(longint'(acc), WIDTH));

`ifdef LSTM_SAT_FLAG_EN
    assign clamped = sat_hit(longint'(acc), WIDTH);
`endif

endmodule

// File: rtl/lstm_seq_cell.sv
// lstm_seq_cell: sequence-aware LSTM cell, one shared MAC over all gates/units.
// LSTM_SAT_FLAG_EN adds the sat_err output.
module lstm_seq_cell
    import lstm_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 12,
    parameter int HIDDEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [HIDDEN*4*WIDTH-1:0]  weight_x,
    input  logic [HIDDEN*4*WIDTH-1:0]  weight_h,
    input  logic [HIDDEN*4*WIDTH-1:0]  bias_x,
    input  logic [HIDDEN*4*WIDTH-1:0]  bias_h,
    input  logic [HIDDEN*WIDTH-1:0]    C_in,
    input  logic [HIDDEN*WIDTH-1:0]    h_in,
    input  logic [WIDTH-1:0]           x_in,
    input  logic                       x_start,
    input  logic                       x_valid,
    output logic                       x_ready,
    output logic [HIDDEN*WIDTH-1:0]    y_out,
    output logic [HIDDEN*WIDTH-1:0]    C_out,
    output logic                       y_valid,
    input  logic                       y_ready
`ifdef LSTM_SAT_FLAG_EN
    ,
    output logic                       sat_err
`endif
);

    localparam int AW = WIDTH + 4;
    localparam int UW = (HIDDEN > 1) ? $clog2(HIDDEN) : 1;
    localparam logic [UW-1:0] U_LAST = UW'(HIDDEN - 1);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_GATE   = ST_GATE;
    localparam logic [1:0] S_UPDATE = ST_UPDATE;
    localparam logic [1:0] S_OUT    = ST_OUT;

    localparam logic [1:0] KI = 2'(GATE_I);
    localparam logic [1:0] KF = 2'(GATE_F);
    localparam logic [1:0] KG = 2'(GATE_G);
    localparam logic [1:0] KO = 2'(GATE_O);

    typedef logic signed [WIDTH-1:0] word_t;

    word_t wx [HIDDEN][4];
    word_t wh [HIDDEN][4];
    word_t bx [HIDDEN][4];
    word_t bh [HIDDEN][4];
    word_t c0 [HIDDEN];
    word_t h0 [HIDDEN];

    for (genvar u = 0; u < HIDDEN; u++) begin : g_unit
        for (genvar k = 0; k < 4; k++) begin : g_gate
            localparam int B = (u * 4 + k) * WIDTH;
            assign wx[u][k] = weight_x[B +: WIDTH];
            assign wh[u][k] = weight_h[B +: WIDTH];
            assign bx[u][k] = bias_x[B +: WIDTH];
            assign bh[u][k] = bias_h[B +: WIDTH];
        end
        assign c0[u] = C_in[u*WIDTH +: WIDTH];
        assign h0[u] = h_in[u*WIDTH +: WIDTH];
    end

    logic [1:0]      state;
    logic [UW-1:0]   unit;
    logic [1:0]      gate;
    word_t           x_q;
    word_t           c_q [HIDDEN];
    word_t           h_q [HIDDEN];
    word_t           gate_q [HIDDEN][4];

    word_t                     mac_a;
    word_t                     mac_b;
    word_t                     mac_y;
    word_t                     act;
    word_t                     c_tanh;
    word_t                     h_new;
    logic signed [AW-1:0]      mac_add;
    logic signed [2*WIDTH-1:0] rec_prod;
    logic signed [2*WIDTH-1:0] ig_prod;
    logic signed [2*WIDTH-1:0] h_prod;

    assign rec_prod = wh[unit][gate] * h_q[unit];
    assign ig_prod  = gate_q[unit][KI] * gate_q[unit][KG];

    // GATE: wx*x + (wh*h + biases); UPDATE: f*c + (i*g)
    always_comb begin
        mac_a   = wx[unit][gate];
        mac_b   = x_q;
        mac_add = AW'(rec_prod >>> FRAC) + AW'(bx[unit][gate])
                + AW'(bh[unit][gate]);
        if (state == S_UPDATE) begin
            mac_a   = gate_q[unit][KF];
            mac_b   = c_q[unit];
            mac_add = AW'(ig_prod >>> FRAC);
        end
    end

`ifdef LSTM_SAT_FLAG_EN
    logic mac_clamped;
    logic h_clamped;
`endif

    lstm_mac #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mac (
        .a      (mac_a),
        .b      (mac_b),
        .addend (mac_add),
        .y      (mac_y)
`ifdef LSTM_SAT_FLAG_EN
        ,
        .clamped(mac_clamped)
`endif
    );

    assign act = (gate == KG) ? WIDTH'(hard_tanh(longint'(mac_y), FRAC))
                              : WIDTH'(hard_sigmoid(longint'(mac_y), FRAC));

    assign c_tanh = WIDTH'(hard_tanh(longint'(mac_y), FRAC));
    assign h_prod = gate_q[unit][KO] * c_tanh;
    assign h_new  = WIDTH'(sat(longint'(h_prod >>> FRAC), WIDTH));

    assign x_ready = rst && (state == S_IDLE);
    assign y_valid = (state == S_OUT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            unit  <= '0;
            gate  <= '0;
            x_q   <= '0;
            y_out <= '0;
            C_out <= '0;
            for (int u = 0; u < HIDDEN; u++) begin
                c_q[u] <= '0;
                h_q[u] <= '0;
                for (int k = 0; k < 4; k++) gate_q[u][k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (x_valid) begin
                        x_q   <= x_in;
                        unit  <= '0;
                        gate  <= '0;
                        state <= S_GATE;
                        if (x_start) begin
                            for (int u = 0; u < HIDDEN; u++) begin
                                c_q[u] <= c0[u];
                                h_q[u] <= h0[u];
                            end
                        end
                    end
                end
                S_GATE: begin
                    gate_q[unit][gate] <= act;
                    gate <= gate + 1'b1;
                    if (gate == 2'd3) begin
                        if (unit == U_LAST) begin
                            unit  <= '0;
                            state <= S_UPDATE;
                        end else begin
                            unit <= unit + 1'b1;
                        end
                    end
                end
                S_UPDATE: begin
                    c_q[unit] <= mac_y;
                    h_q[unit] <= h_new;
                    for (int u = 0; u < HIDDEN; u++) begin
                        if (unit == UW'(u)) begin
                            y_out[u*WIDTH +: WIDTH] <= h_new;
                            C_out[u*WIDTH +: WIDTH] <= mac_y;
                        end
                    end
                    if (unit == U_LAST) begin
                        unit  <= '0;
                        state <= S_OUT;
                    end else begin
                        unit <= unit + 1'b1;
                    end
                end
                S_OUT: begin
                    if (y_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LSTM_SAT_FLAG_EN
    assign h_clamped = sat_hit(longint'(h_prod >>> FRAC), WIDTH);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sat_err <= 1'b0;
        end else if (x_valid && x_ready) begin
            sat_err <= 1'b0;
        end else if (state == S_GATE) begin
            sat_err <= sat_err | mac_clamped;
        end else if (state == S_UPDATE) begin
            sat_err <= sat_err | mac_clamped | h_clamped;
        end
    end
`endif

endmodule

// File: tb/tb_lstm_seq_cell.sv
// tb_lstm_seq_cell: randomized steps checked against a behavioural LSTM model.
// Build with LSTM_SAT_FLAG_EN to also check sat_err.
module tb_lstm_seq_cell;

    localparam int W = 16;
    localparam int F = 12;
    localparam int H = 4;
    localparam int G = 4 * H;
    localparam int LAT = 5 * H + 1;
    localparam int PERIOD = 5 * H + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [G*W-1:0]   weight_x = '0;
    logic [G*W-1:0]   weight_h = '0;
    logic [G*W-1:0]   bias_x = '0;
    logic [G*W-1:0]   bias_h = '0;
    logic [H*W-1:0]   C_in = '0;
    logic [H*W-1:0]   h_in = '0;
    logic [W-1:0]     x_in = '0;
    logic             x_start = 1'b0;
    logic             x_valid = 1'b0;
    logic             x_ready;
    logic [H*W-1:0]   y_out;
    logic [H*W-1:0]   C_out;
    logic             y_valid;
    logic             y_ready = 1'b1;
`ifdef LSTM_SAT_FLAG_EN
    logic             sat_err;
`endif

    lstm_seq_cell #(
        .WIDTH  (W),
        .FRAC   (F),
        .HIDDEN (H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .weight_x (weight_x),
        .weight_h (weight_h),
        .bias_x   (bias_x),
        .bias_h   (bias_h),
        .C_in     (C_in),
        .h_in     (h_in),
        .x_in     (x_in),
        .x_start  (x_start),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .y_out    (y_out),
        .C_out    (C_out),
        .y_valid  (y_valid),
        .y_ready  (y_ready)
`ifdef LSTM_SAT_FLAG_EN
        ,
        .sat_err  (sat_err)
`endif
    );

    always #5 clk = ~clk;

    int wx [G];
    int wh [G];
    int bx [G];
    int bh [G];
    int cin [H];
    int hin [H];

    longint       m_c [H];
    longint       m_h [H];
    logic [H*W-1:0] exp_y;
    logic [H*W-1:0] exp_c;
    bit           exp_sat;
    bit           exp_pending;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int accept_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    function automatic longint wrap_acc(input longint v);
        longint m;
        m = v & ((longint'(1) <<< (W + 4)) - 1);
        if (m >= (longint'(1) <<< (W + 3))) m -= longint'(1) <<< (W + 4);
        return m;
    endfunction

    function automatic longint sat_m(input longint v);
        if (v > 32767) begin exp_sat = 1; return 32767; end
        if (v < -32768) begin exp_sat = 1; return -32768; end
        return v;
    endfunction

    function automatic longint hsig(input longint pre);
        longint v;
        v = (pre >>> 2) + 2048;
        return (v < 0) ? 0 : (v > 4096) ? 4096 : v;
    endfunction

    function automatic longint htanh(input longint pre);
        return (pre > 4096) ? 4096 : (pre < -4096) ? -4096 : pre;
    endfunction

    task automatic model_step(input int x, input bit start);
        longint gv [H][4];
        longint pre;
        if (start) begin
            for (int u = 0; u < H; u++) begin
                m_c[u] = cin[u];
                m_h[u] = hin[u];
            end
        end
        exp_sat = 0;
        for (int u = 0; u < H; u++) begin
            for (int k = 0; k < 4; k++) begin
                pre = (longint'(wx[u*4+k]) * x) >>> F;
                pre += (longint'(wh[u*4+k]) * m_h[u]) >>> F;
                pre = sat_m(wrap_acc(pre + bx[u*4+k] + bh[u*4+k]));
                gv[u][k] = (k == 2) ? htanh(pre) : hsig(pre);
            end
        end
        for (int u = 0; u < H; u++) begin
            m_c[u] = sat_m(wrap_acc(((gv[u][1] * m_c[u]) >>> F)
                                  + ((gv[u][0] * gv[u][2]) >>> F)));
            m_h[u] = sat_m((gv[u][3] * htanh(m_c[u])) >>> F);
            exp_y[u*W +: W] = W'(m_h[u]);
            exp_c[u*W +: W] = W'(m_c[u]);
        end
    endtask

    task automatic pack_inputs();
        for (int i = 0; i < G; i++) begin
            weight_x[i*W +: W] = W'(wx[i]);
            weight_h[i*W +: W] = W'(wh[i]);
            bias_x[i*W +: W]   = W'(bx[i]);
            bias_h[i*W +: W]   = W'(bh[i]);
        end
        for (int u = 0; u < H; u++) begin
            C_in[u*W +: W] = W'(cin[u]);
            h_in[u*W +: W] = W'(hin[u]);
        end
    endtask

    task automatic set_all(input int vwx, input int vc);
        for (int i = 0; i < G; i++) begin
            wx[i] = vwx;
            wh[i] = 0;
            bx[i] = 0;
            bh[i] = 0;
        end
        for (int u = 0; u < H; u++) begin
            cin[u] = vc;
            hin[u] = 0;
        end
        pack_inputs();
    endtask

    function automatic int rnd_word(input bit full);
        logic signed [W-1:0] v;
        if (full) v = W'($urandom);
        else v = W'(int'($urandom_range(0, 16383)) - 8192);
        return int'(v);
    endfunction

    task automatic randomize_inputs(input bit full);
        for (int i = 0; i < G; i++) begin
            wx[i] = rnd_word(full);
            wh[i] = rnd_word(full);
            bx[i] = rnd_word(full);
            bh[i] = rnd_word(full);
        end
        for (int u = 0; u < H; u++) begin
            cin[u] = rnd_word(full);
            hin[u] = rnd_word(full);
        end
        pack_inputs();
    endtask

    // Compare process: every cycle an output is presented it must match the model.
    always @(negedge clk) begin
        if (rst && y_valid) begin
            if (!exp_pending) begin
                chk("spurious_y_valid", y_valid, 0);
            end else begin
                chk("y_out", y_out, exp_y);
                chk("C_out", C_out, exp_c);
                chk("x_ready_during_out", x_ready, 0);
`ifdef LSTM_SAT_FLAG_EN
                chk("sat_err", sat_err, exp_sat);
`endif
            end
        end
    end

    task automatic run_step(input int x, input bit start, input int hold);
        int n;
        @(negedge clk);
        x_in    = W'(x);
        x_start = start;
        x_valid = 1'b1;
        y_ready = (hold == 0);
        n = 0;
        while (!x_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!x_ready) begin
            chk("accept_timeout", x_ready, 1);
            x_valid = 1'b0;
            return;
        end
        accept_cyc = cyc;
        model_step(x, start);
        exp_pending = 1;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        x_start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!y_valid && n < 200);
        chk("latency", n, LAT);
        if (!y_valid) begin
            exp_pending = 0;
            return;
        end
        if (hold > 0) begin
            x_valid = 1'b1;
            x_in    = W'($urandom);
            for (int i = 0; i < hold; i++) begin
                chk("hold_x_ready", x_ready, 0);
                chk("hold_y_valid", y_valid, 1);
                @(negedge clk);
            end
            y_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_pending = 0;
        x_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t1_acc;
        int seen;
        int n;
        exp_pending = 0;
        exp_sat = 0;
        for (int u = 0; u < H; u++) begin
            m_c[u] = 0;
            m_h[u] = 0;
        end
        set_all(0, 0);

        repeat (3) @(negedge clk);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_C_out", C_out, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("release_x_ready", x_ready, 1);

        // zero weights, c=1.0: gates i=f=o=0.5, g=0
        set_all(0, 4096);
        run_step(4096, 1, 0);
        t1_acc = accept_cyc;
        chk("t1_model_c", m_c[0], 2048);
        chk("t1_model_h", m_h[0], 1024);
        chk("t1_C_out", C_out, {H{16'd2048}});
        chk("t1_y_out", y_out, {H{16'd1024}});

        set_all(0, 777);
        run_step(4096, 0, 0);
        chk("throughput", accept_cyc - t1_acc, PERIOD);
        chk("t2_model_c", m_c[1], 1024);
        chk("t2_model_h", m_h[1], 512);
        chk("t2_C_out", C_out, {H{16'd1024}});
        chk("t2_y_out", y_out, {H{16'd512}});

        set_all(32767, 4096);
        run_step(32767, 1, 0);
        chk("t3_model_c", m_c[2], 8192);
        chk("t3_model_h", m_h[3], 4096);
        chk("t3_model_sat", exp_sat, 1);
        chk("t3_C_out", C_out, {H{16'd8192}});
        chk("t3_y_out", y_out, {H{16'd4096}});

        randomize_inputs(0);
        run_step(rnd_word(0), 1, 10);
        randomize_inputs(0);
        run_step(rnd_word(0), 0, 0);

        // abort a step mid-GATE with reset
        set_all(0, 0);
        @(negedge clk);
        x_in = W'(4096);
        x_start = 1'b0;
        x_valid = 1'b1;
        n = 0;
        while (!x_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_accept", x_ready, 1);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < H; u++) begin
            m_c[u] = 0;
            m_h[u] = 0;
        end
        @(negedge clk);
        chk("abort_rst_x_ready", x_ready, 0);
        rst = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (y_valid) seen++;
        end
        chk("abort_no_output", seen, 0);
        run_step(4096, 0, 0);
        chk("abort_C_out", C_out, 0);
        chk("abort_y_out", y_out, 0);

        for (int s = 0; s < 40; s++) begin
            randomize_inputs($urandom_range(0, 3) == 0);
            run_step(rnd_word($urandom_range(0, 3) == 0),
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
